game_speed_scheduler: RTL

Game-flow controller that sequences the dino scroll-speed datapath. It runs the IDLE/RUN/PAUSED/OVER game FSM and ramps a fixed-point speed every STEP_INTERVAL frames, saturating at MAXIMUM_SPEED. Each frame it accumulates speed into a fractional scroll accumulator and issues an integer pixel step to the obstacle/ground scrollers. It sits between the input/collision logic and the scrolling sprite modules.

---
 rtl/game_speed_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/game_speed_scheduler.sv
// game_speed_scheduler
// ---------------------------------------------------------------------------
// Purpose:
//   Game-flow controller for the dino scroll-speed datapath. Runs the
//   IDLE/RUN/PAUSED/OVER game FSM. While running it raises a fixed-point
//   scroll speed every STEP_INTERVAL frames, saturating at MAXIMUM_SPEED.
//   On every frame it adds the speed into a fractional accumulator and
//   sends the whole-pixel part to the obstacle/ground scrollers.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset (highest priority)
//   frame_tick    one-cycle pulse per video frame
//   start         one-cycle pulse, debounced start button
//   pause         one-cycle pulse, debounced pause toggle
//   collision     one-cycle pulse, dino hit an obstacle
//   speed         current fixed-point speed (FRAC_PART_SIZE fraction bits)
//   scroll_px     integer pixels to scroll; holds between pulses
//   scroll_valid  one-cycle pulse qualifying scroll_px
//   state         FSM state: 0=IDLE, 1=RUN, 2=PAUSED, 3=OVER
//   running       high iff state==RUN (registered)
//
// Handshake: there is no back-pressure. scroll_valid is a single-cycle
// strobe; the consumer must accept scroll_px in the cycle the strobe is high.
// The value stays on scroll_px afterwards for display/debug use.
// ---------------------------------------------------------------------------
module game_speed_scheduler #(
  parameter int FRAC_PART_SIZE = 2,
  parameter int SPEED_W        = 12 + FRAC_PART_SIZE,
  parameter int DEFAULT_SPEED  = 1 << FRAC_PART_SIZE,
  parameter int MAXIMUM_SPEED  = 46,
  parameter int STEP_INTERVAL  = 600,
  parameter int STEP_SIZE      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        collision,
  output logic [SPEED_W-1:0]          speed,
  output logic [SPEED_W-FRAC_PART_SIZE-1:0] scroll_px,
  output logic                        scroll_valid,
  output logic [1:0]                  state,
  output logic                        running
);

  localparam int CNT_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int PX_W  = SPEED_W - FRAC_PART_SIZE;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STEP_INTERVAL - 1);
  localparam logic [SPEED_W-1:0] SPEED_DEF = SPEED_W'(DEFAULT_SPEED);
  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAXIMUM_SPEED);
  localparam logic [SPEED_W:0]   SPEED_MAX_X = (SPEED_W + 1)'(MAXIMUM_SPEED);
  localparam logic [SPEED_W:0]   STEP_X      = (SPEED_W + 1)'(STEP_SIZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [SPEED_W-1:0]        speed_q, speed_d;
  logic [CNT_W-1:0]          frame_cnt_q, frame_cnt_d;
  logic [FRAC_PART_SIZE-1:0] frac_acc_q, frac_acc_d;
  logic [PX_W-1:0]           scroll_px_q, scroll_px_d;
  logic                      scroll_valid_q, scroll_valid_d;
  logic                      running_q, running_d;

  // One extra bit on both sums so neither can wrap before being inspected.
  logic [SPEED_W:0] scroll_sum;
  logic [SPEED_W:0] speed_inc;
  logic [SPEED_W-1:0] speed_sat;

  assign scroll_sum = {1'b0, speed_q} + (SPEED_W + 1)'(frac_acc_q);
  assign speed_inc  = {1'b0, speed_q} + STEP_X;
  // >= so that a step larger than the remaining headroom still clamps.
  assign speed_sat  = (speed_inc >= SPEED_MAX_X) ? SPEED_MAX : speed_inc[SPEED_W-1:0];

  always_comb begin
    state_d        = state_q;
    speed_d        = speed_q;
    frame_cnt_d    = frame_cnt_q;
    frac_acc_d     = frac_acc_q;
    scroll_px_d    = scroll_px_q;
    scroll_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        speed_d = SPEED_DEF;
        if (start) begin
          state_d     = S_RUN;
          frame_cnt_d = '0;
          frac_acc_d  = '0;
        end
      end

      S_RUN: begin
        // collision > pause > frame_tick; a tick that loses is simply dropped.
        if (collision) begin
          state_d = S_OVER;
        end else if (pause) begin
          state_d = S_PAUSED;
        end else if (frame_tick) begin
          // Scroll uses the speed before this frame's possible step.
          scroll_px_d    = PX_W'(scroll_sum >> FRAC_PART_SIZE);
          scroll_valid_d = 1'b1;
          frac_acc_d     = scroll_sum[FRAC_PART_SIZE-1:0];
          if (frame_cnt_q == CNT_LAST) begin
            frame_cnt_d = '0;
            speed_d     = speed_sat;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      S_PAUSED: begin
        if (pause) begin
          state_d = S_RUN;
        end
      end

      S_OVER: begin
        // speed keeps its final value for the score display until restart.
        if (start) begin
          state_d     = S_RUN;
          speed_d     = SPEED_DEF;
          frame_cnt_d = '0;
          frac_acc_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      speed_q        <= SPEED_DEF;
      frame_cnt_q    <= '0;
      frac_acc_q     <= '0;
      scroll_px_q    <= '0;
      scroll_valid_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      speed_q        <= speed_d;
      frame_cnt_q    <= frame_cnt_d;
      frac_acc_q     <= frac_acc_d;
      scroll_px_q    <= scroll_px_d;
      scroll_valid_q <= scroll_valid_d;
      running_q      <= running_d;
    end
  end

  assign speed        = speed_q;
  assign scroll_px    = scroll_px_q;
  assign scroll_valid = scroll_valid_q;
  assign state        = state_q;
  assign running      = running_q;

endmodule
